alu_wb_arbiter: RTL and testbench
=================================

# alu_wb_arbiter

Register-file write-back arbiter sitting directly downstream of the SIMD/SIMF ALU write-back queues. Each ALU raises `rfa_queue_entry_valid` when its queue head holds a finished instruction. This block grants exactly one write-back per cycle by pulsing that ALU's `rfa_queue_entry_serviced`, which pops its queue. The LSU write port has priority but is bounded by a streak limit so ALUs cannot starve; ALU ports are served round-robin.

## Interface
Parameters:
- `NUM_PORTS`, 8: number of ALU queues (indices 0-3 SIMD, 4-7 SIMF).
- `LSU_MAX_STREAK`, 4: maximum consecutive LSU grants while any ALU entry is pending.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_entry_valid`  in  NUM_PORTS  per-ALU `rfa_queue_entry_valid`.
- `lsu_wr_req`  in  1  LSU requests the register-file write port this cycle.
- `alu_entry_serviced`  out  NUM_PORTS  one-hot (or zero) grant; drives each ALU's `rfa_queue_entry_serviced`.
- `lsu_wr_grant`  out  1  LSU owns the write port this cycle.
- `grant_valid`  out  1  some ALU port is granted this cycle.
- `grant_idx`  out  $clog2(NUM_PORTS)  index of the granted ALU port; 0 when `grant_valid`=0.
- `lsu_wait`  out  1  `lsu_wr_req & ~lsu_wr_grant`.

## Operation
- State: `rr_ptr` ($clog2(NUM_PORTS) bits) and `lsu_streak` ($clog2(LSU_MAX_STREAK+1) bits).
- `alu_any` = OR of `alu_entry_valid`.
- LSU wins if `lsu_wr_req` and !(`alu_any` and `lsu_streak`==LSU_MAX_STREAK). Otherwise, if `alu_any`, an ALU wins.
- ALU pick: the first set bit of `alu_entry_valid` when scanning upward from `rr_ptr` with wrap (index NUM_PORTS-1 wraps to 0).
- Exactly one of {LSU, one ALU, nobody} is granted per cycle. `alu_entry_serviced` is never multi-hot.
- `rr_ptr` update: on an ALU grant at index i, `rr_ptr` <= (i+1) mod NUM_PORTS. Otherwise it holds.
- `lsu_streak` update:
  - LSU granted and `alu_any`: +1, saturating at LSU_MAX_STREAK.
  - LSU granted and !`alu_any`: hold 0.
  - Any cycle the LSU is not granted: 0.
- Forced ALU grant (streak at limit) resets `lsu_streak` to 0, so the LSU regains priority next cycle.
- A valid that stays high after its serviced pulse is treated as a new entry. The queue must have popped on the serviced edge, so the valid reflects the next head.

## Timing
- Grants are combinational from the current inputs and registered state; there is zero-cycle latency from valid to serviced.
- State updates on the clock edge in the same cycle as the grant.
- Reset (async): `rr_ptr`=0, `lsu_streak`=0. While `rst` is high, all outputs are forced to 0 (`alu_entry_serviced`=0, `lsu_wr_grant`=0, `grant_valid`=0, `grant_idx`=0, `lsu_wait`=0).
- Reset mid-stream drops any in-flight grant. The first cycle after deassertion arbitrates from `rr_ptr`=0.
- No valid and no request: all outputs 0, state holds.
- The LSU is never blocked more than 1 cycle after a streak of LSU_MAX_STREAK grants.
- Any pending ALU entry is granted within NUM_PORTS×(LSU_MAX_STREAK+1) cycles.

## Structure
- Shared package holds:
  - defaults for NUM_PORTS and LSU_MAX_STREAK;
  - port-index constants for the SIMD0-3 and SIMF0-3 positions;
  - index and streak widths derived via $clog2.
- One sub-module, `rr_priority_picker`: combinational rotate-by-`rr_ptr`, priority encode, rotate back. Outputs a one-hot vector, an index and a found flag.
- The top level holds the pointer and streak registers and the LSU/ALU select logic.

## Test plan
- Reset, then `alu_entry_valid`=8'h00, `lsu_wr_req`=0 -> all outputs 0, `rr_ptr` stays 0.
- `alu_entry_valid`=8'hFF held for 8 cycles, no LSU -> grants idx 0,1,…,7. Cycle 9 grants idx 0 again.
- `rr_ptr`=6, `alu_entry_valid`=8'h21 -> grant idx 0 (wrap), then `rr_ptr`=1. Next cycle with the same valids -> grant idx 5.
- `lsu_wr_req`=1 continuously, `alu_entry_valid`=8'h04 -> 4 LSU grants, then 1 cycle `alu_entry_serviced`=8'h04 with `lsu_wait`=1, then LSU grants again.
- `lsu_wr_req`=1, `alu_entry_valid`=0 for 10 cycles -> LSU granted every cycle, `lsu_streak` stays 0. Raising `alu_entry_valid`=8'h01 -> ALU granted only after 4 more LSU cycles.
- Assert `rst` asynchronously mid-cycle while grant idx 3 is active -> all outputs drop to 0 immediately. After release with valid 8'h18, grant idx 3 (scan from 0).

Source files
------------

// File: rtl/alu_wb_arbiter_pkg.sv
// Shared constants for the ALU write-back arbiter.
// Covers default sizing, ALU queue positions and derived widths.
package alu_wb_arbiter_pkg;

    localparam int unsigned NUM_PORTS_DEF      = 8;
    localparam int unsigned LSU_MAX_STREAK_DEF = 4;

    localparam int unsigned PORT_SIMD0 = 0;
    localparam int unsigned PORT_SIMD1 = 1;
    localparam int unsigned PORT_SIMD2 = 2;
    localparam int unsigned PORT_SIMD3 = 3;
    localparam int unsigned PORT_SIMF0 = 4;
    localparam int unsigned PORT_SIMF1 = 5;
    localparam int unsigned PORT_SIMF2 = 6;
    localparam int unsigned PORT_SIMF3 = 7;

    localparam int unsigned IDX_W    = $clog2(NUM_PORTS_DEF);
    localparam int unsigned STREAK_W = $clog2(LSU_MAX_STREAK_DEF + 1);

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotate the request vector by the pointer,
// priority-encode the lowest set bit, then rotate the index back.
module rr_priority_picker
    import alu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [PTR_W-1:0]     idx,
    output logic                 found
);

    localparam logic [PTR_W:0] NP = (PTR_W + 1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0] rotated;
    logic [PTR_W-1:0]     offset;
    logic [PTR_W:0]       sum;

    // Bit 0 of the rotated vector corresponds to the port at rr_ptr.
    assign rotated = NUM_PORTS'({valid, valid} >> rr_ptr);

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = i[PTR_W-1:0];
            end
        end
        sum = {1'b0, offset} + {1'b0, rr_ptr};
        if (sum >= NP) begin
            sum = sum - NP;
        end
        idx         = sum[PTR_W-1:0];
        onehot      = '0;
        onehot[idx] = found;
    end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Register-file write-back arbiter: LSU priority bounded by a streak limit,
// round-robin among ALU write-back queues, one grant per cycle.
module alu_wb_arbiter
    import alu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = NUM_PORTS_DEF,
    parameter int unsigned LSU_MAX_STREAK = LSU_MAX_STREAK_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         alu_entry_valid,
    input  logic                         lsu_wr_req,
    output logic [NUM_PORTS-1:0]         alu_entry_serviced,
    output logic                         lsu_wr_grant,
    output logic                         grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         lsu_wait
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned STR_W = $clog2(LSU_MAX_STREAK + 1);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_PORTS - 1);
    localparam logic [STR_W-1:0] STREAK_MAX = STR_W'(LSU_MAX_STREAK);

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [STR_W-1:0]     lsu_streak_q, lsu_streak_d;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 alu_any, streak_full, lsu_win, alu_win;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .valid  (alu_entry_valid),
        .rr_ptr (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        alu_any     = |alu_entry_valid;
        streak_full = (lsu_streak_q == STREAK_MAX);
        lsu_win     = lsu_wr_req & ~(alu_any & streak_full);
        alu_win     = ~lsu_win & pick_found;

        rr_ptr_d = rr_ptr_q;
        if (alu_win) begin
            rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end

        // Streak only counts while ALUs are actually waiting behind the LSU.
        lsu_streak_d = '0;
        if (lsu_win && alu_any) begin
            lsu_streak_d = streak_full ? lsu_streak_q : lsu_streak_q + 1'b1;
        end
    end

    always_comb begin
        alu_entry_serviced = '0;
        lsu_wr_grant       = 1'b0;
        grant_valid        = 1'b0;
        grant_idx          = '0;
        lsu_wait           = 1'b0;
        if (!rst) begin
            alu_entry_serviced = alu_win ? pick_onehot : '0;
            lsu_wr_grant       = lsu_win;
            grant_valid        = alu_win;
            grant_idx          = alu_win ? pick_idx : '0;
            lsu_wait           = lsu_wr_req & ~lsu_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lsu_streak_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lsu_streak_q <= lsu_streak_d;
        end
    end

endmodule

// File: tb/tb_alu_wb_arbiter.sv
// Self-checking bench for alu_wb_arbiter against a behavioural arbitration model.
module tb_alu_wb_arbiter;

    localparam int NP  = 8;
    localparam int MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_entry_valid;
    logic       lsu_wr_req;
    logic [7:0] alu_entry_serviced;
    logic       lsu_wr_grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       lsu_wait;

    alu_wb_arbiter #(
        .NUM_PORTS      (NP),
        .LSU_MAX_STREAK (MAX)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_entry_valid    (alu_entry_valid),
        .lsu_wr_req         (lsu_wr_req),
        .alu_entry_serviced (alu_entry_serviced),
        .lsu_wr_grant       (lsu_wr_grant),
        .grant_valid        (grant_valid),
        .grant_idx          (grant_idx),
        .lsu_wait           (lsu_wait)
    );

    always #5 clk = ~clk;

    // Observed vector: {serviced[7:0], lsu_grant, grant_valid, idx[2:0], lsu_wait}
    logic [13:0] obs;
    assign obs = {alu_entry_serviced, lsu_wr_grant, grant_valid, grant_idx, lsu_wait};

    int n_checks = 0;
    int n_fail   = 0;
    int m_rr     = 0;
    int m_streak = 0;
    logic [13:0] exp_o;

    // Expected outputs from the arbitration rules, given model state.
    function automatic logic [13:0] model_out(input logic [7:0] v, input logic req);
        logic [7:0] serv;
        logic       lsu, gv, any;
        int         idx;
        any  = (v != 8'h00);
        lsu  = req && !(any && m_streak == MAX);
        serv = 8'h00;
        gv   = 1'b0;
        idx  = 0;
        if (!lsu && any) begin
            for (int k = 0; k < NP; k++) begin
                if (!gv && v[(m_rr + k) % NP]) begin
                    gv   = 1'b1;
                    idx  = (m_rr + k) % NP;
                    serv[idx] = 1'b1;
                end
            end
        end
        return {serv, lsu, gv, idx[2:0], req && !lsu};
    endfunction

    function automatic void model_update(input logic [7:0] v, input logic [13:0] e);
        if (e[4]) m_rr = (int'(e[3:1]) + 1) % NP;
        if (e[5] && v != 8'h00) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
        else m_streak = 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        alu_entry_valid = 8'hFF;
        lsu_wr_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_forced_zero: got %h expected %h", obs, 14'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_rr = 0;
        m_streak = 0;
        alu_entry_valid = 8'h00;
        lsu_wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o || obs !== 14'h0) begin
                n_fail++;
                $display("FAIL idle_outputs cycle %0d: got %h expected %h", i, obs, exp_o);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        alu_entry_valid = 8'hFF;
        lsu_wr_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o || grant_idx !== 3'(i % NP)) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d: got %h expected %h (idx %0d)",
                         i, obs, exp_o, i % NP);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] vals [3];
        int         want [3];
        vals = '{8'h20, 8'h21, 8'h21};
        want = '{5, 0, 5};
        lsu_wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_entry_valid = vals[i];
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o || grant_idx !== 3'(want[i]) || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap cycle %0d: got %h expected %h (idx %0d)",
                         i, obs, exp_o, want[i]);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lsu_streak();
        alu_entry_valid = 8'h04;
        lsu_wr_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            logic alu_turn;
            alu_turn = (i == 4) || (i == 9);
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o || lsu_wr_grant !== !alu_turn ||
                alu_entry_serviced !== (alu_turn ? 8'h04 : 8'h00) || lsu_wait !== alu_turn) begin
                n_fail++;
                $display("FAIL lsu_streak cycle %0d: got %h expected %h", i, obs, exp_o);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lsu_only();
        lsu_wr_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alu_entry_valid = (i < 10) ? 8'h00 : 8'h01;
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o || lsu_wr_grant !== (i != 14)) begin
                n_fail++;
                $display("FAIL lsu_only cycle %0d: got %h expected %h", i, obs, exp_o);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            alu_entry_valid = 8'($urandom) & 8'($urandom);
            lsu_wr_req = ($urandom_range(0, 3) != 0);
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL random cycle %0d: v=%h req=%b got %h expected %h",
                         i, alu_entry_valid, lsu_wr_req, obs, exp_o);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        alu_entry_valid = 8'h08;
        lsu_wr_req = 1'b0;
        #1;
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_grant: got valid %b idx %0d expected 1 idx 3",
                     grant_valid, grant_idx);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %h expected %h", obs, 14'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_rr = 0;
        m_streak = 0;
        alu_entry_valid = 8'h18;
        for (int i = 0; i < 3; i++) begin
            exp_o = model_out(alu_entry_valid, lsu_wr_req);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o || (i == 0 && grant_idx !== 3'd3)) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got %h expected %h", i, obs, exp_o);
            end
            model_update(alu_entry_valid, exp_o);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_entry_valid = 8'h00;
        lsu_wr_req = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_wrap();
        test_lsu_streak();
        test_lsu_only();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
